// File: rtl/clint_access_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// clint_pkg
// Shared types for the CLINT access sequencer:
//   clint_op_e    - 64-bit request opcode seen on req_op_i
//   state_e       - sequencer FSM states
//   step_t        - one 32-bit bus access of a 64-bit sequence
//   step_of()     - per-op step tables (ordering chosen to avoid spurious
//                   timer interrupts and torn reads)
//   last_idx()    - index of the final step of each op
//   op_is_time()  - op targets mtime rather than mtimecmp
// -----------------------------------------------------------------------------
package clint_pkg;

  typedef enum logic [1:0] {
    OP_SET_CMP   = 2'd0,
    OP_READ_CMP  = 2'd1,
    OP_SET_TIME  = 2'd2,
    OP_READ_TIME = 2'd3
  } clint_op_e;

  localparam logic [31:0] CLINT_MTIMECMP_ADDR = 32'h2000_0C00;
  localparam logic [31:0] CLINT_MTIME_ADDR    = 32'h2000_0C08;

  // Source of the 32-bit write word for a write step.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_ONES = 2'd1,
    SRC_LO   = 2'd2,
    SRC_HI   = 2'd3
  } sel_src_e;

  typedef struct packed {
    logic     we;
    logic [2:0] adr_off;
    sel_src_e sel_src;
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_RDCAP = 3'd2,
    ST_NEXT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // SET_CMP parks the high word at all-ones first so the compare value is
  // never transiently below both the old and the new value. SET_TIME zeroes
  // the low word first so no carry can ripple into the new high word.
  // READ_TIME brackets the low word with two high-word reads.
  function automatic step_t step_of(clint_op_e op, logic [1:0] idx);
    step_t s;
    s = '{we: 1'b0, adr_off: 3'd0, sel_src: SRC_ZERO};
    case (op)
      OP_SET_CMP: begin
        case (idx)
          2'd0:    s = '{we: 1'b1, adr_off: 3'd4, sel_src: SRC_ONES};
          2'd1:    s = '{we: 1'b1, adr_off: 3'd0, sel_src: SRC_LO};
          default: s = '{we: 1'b1, adr_off: 3'd4, sel_src: SRC_HI};
        endcase
      end
      OP_SET_TIME: begin
        case (idx)
          2'd0:    s = '{we: 1'b1, adr_off: 3'd0, sel_src: SRC_ZERO};
          2'd1:    s = '{we: 1'b1, adr_off: 3'd4, sel_src: SRC_HI};
          default: s = '{we: 1'b1, adr_off: 3'd0, sel_src: SRC_LO};
        endcase
      end
      OP_READ_CMP: begin
        case (idx)
          2'd0:    s = '{we: 1'b0, adr_off: 3'd0, sel_src: SRC_ZERO};
          default: s = '{we: 1'b0, adr_off: 3'd4, sel_src: SRC_ZERO};
        endcase
      end
      default: begin
        case (idx)
          2'd1:    s = '{we: 1'b0, adr_off: 3'd0, sel_src: SRC_ZERO};
          default: s = '{we: 1'b0, adr_off: 3'd4, sel_src: SRC_ZERO};
        endcase
      end
    endcase
    return s;
  endfunction

  function automatic logic [1:0] last_idx(clint_op_e op);
    return (op == OP_READ_CMP) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic op_is_time(clint_op_e op);
    return (op == OP_SET_TIME) || (op == OP_READ_TIME);
  endfunction

endpackage

// File: rtl/clint_access_sequencer_wb_access.sv
// -----------------------------------------------------------------------------
// clint_wb_access
// Performs one Wishbone classic transfer for the sequencer.
//   clk, rst         clock / synchronous active-high reset
//   i_start          held high for the whole ISSUE phase (drives cyc/stb)
//   i_cap            high in the cycle after a read ack; captures wbm_dat_i
//   i_we/i_adr/i_wdat access attributes
//   o_done           ack seen while issuing (combinational)
//   o_timeout        ACK_TIMEOUT cycles of stb without ack
//   o_rdat           captured read word, valid from the cycle after i_cap
//   wbm_*            Wishbone master signals
// -----------------------------------------------------------------------------
module clint_wb_access
  import clint_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_cap,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  output logic        o_done,
  output logic        o_timeout,
  output logic [31:0] o_rdat,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic [31:0]   r_rdat;

  // Address/data are forced to zero outside an access so the bus is quiet.
  assign wbm_cyc_o = i_start;
  assign wbm_stb_o = i_start;
  assign wbm_we_o  = i_start & i_we;
  assign wbm_adr_o = i_start ? i_adr : 32'd0;
  assign wbm_dat_o = (i_start & i_we) ? i_wdat : 32'd0;

  assign o_done    = i_start & wbm_ack_i;
  // An ack in the final allowed cycle still wins over the timeout.
  assign o_timeout = i_start & ~wbm_ack_i & (r_wait_cnt == CW'(ACK_TIMEOUT - 1));
  assign o_rdat    = r_rdat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (i_start && !wbm_ack_i) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Slave read data is registered, so it is sampled one cycle after the ack.
  always_ff @(posedge clk) begin
    if (i_cap) begin
      r_rdat <= wbm_dat_i;
    end
  end

endmodule

// File: rtl/clint_access_sequencer.sv
// -----------------------------------------------------------------------------
// clint_access_sequencer
// Wishbone master that turns one-shot 64-bit CLINT timer requests into
// ordered 32-bit access sequences (glitch-free mtimecmp update, untorn mtime
// read with bounded retries).
//   wb_clk_i, wb_rst_i      clock / synchronous active-high reset
//   req_valid_i/req_ready_o request handshake (ready only while idle)
//   req_op_i, req_data_i    opcode (clint_op_e) and 64-bit write value
//   rsp_valid_o             one-cycle completion pulse
//   rsp_data_o, rsp_err_o   read result (0 for writes), timeout/retry error
//   busy_o                  inverse of req_ready_o
//   wbm_*                   Wishbone master port to the CLINT
// -----------------------------------------------------------------------------
module clint_access_sequencer
  import clint_pkg::*;
#(
  parameter logic [31:0] MTIMECMP_ADDR = CLINT_MTIMECMP_ADDR,
  parameter logic [31:0] MTIME_ADDR    = CLINT_MTIME_ADDR,
  parameter int          ACK_TIMEOUT   = 16,
  parameter int          MAX_RETRY     = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [63:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  state_e         r_state;
  state_e         w_state_nxt;
  clint_op_e      r_op;
  logic [63:0]    r_data;
  logic [1:0]     r_idx;
  logic [RW-1:0]  r_retry;
  logic [31:0]    r_lo;
  logic [31:0]    r_h1;
  logic [63:0]    r_rsp_data;
  logic           r_err;

  step_t          w_step;
  logic           w_last;
  logic [31:0]    w_adr;
  logic [31:0]    w_wdat;
  logic           w_issue;
  logic           w_cap;
  logic           w_done;
  logic           w_timeout;
  logic [31:0]    w_rdat;
  logic           w_hi_mismatch;
  logic           w_retry_left;
  logic           w_restart;

  assign w_step = step_of(r_op, r_idx);
  assign w_last = (r_idx == last_idx(r_op));
  assign w_adr  = (op_is_time(r_op) ? MTIME_ADDR : MTIMECMP_ADDR) + {29'd0, w_step.adr_off};

  always_comb begin
    w_wdat = 32'd0;
    case (w_step.sel_src)
      SRC_ONES: w_wdat = 32'hFFFF_FFFF;
      SRC_LO:   w_wdat = r_data[31:0];
      SRC_HI:   w_wdat = r_data[63:32];
      default:  w_wdat = 32'd0;
    endcase
  end

  // In NEXT after the final READ_TIME step, w_rdat holds h2.
  assign w_hi_mismatch = (w_rdat != r_h1);
  assign w_retry_left  = (r_retry != RW'(MAX_RETRY));
  assign w_restart     = (r_op == OP_READ_TIME) && w_last && w_hi_mismatch && w_retry_left;

  clint_wb_access #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_access (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .i_start   (w_issue),
    .i_cap     (w_cap),
    .i_we      (w_step.we),
    .i_adr     (w_adr),
    .i_wdat    (w_wdat),
    .o_done    (w_done),
    .o_timeout (w_timeout),
    .o_rdat    (w_rdat),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_cap       = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_issue = 1'b1;
        if (w_done)         w_state_nxt = w_step.we ? ST_NEXT : ST_RDCAP;
        else if (w_timeout) w_state_nxt = ST_RESP;
      end
      ST_RDCAP: begin
        w_cap       = 1'b1;
        w_state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        w_state_nxt = (w_restart || !w_last) ? ST_ISSUE : ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o     = ~req_ready_o;
  assign rsp_data_o = r_rsp_data;
  assign rsp_err_o  = rsp_valid_o & r_err;

  // Sequencing and result assembly.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_op       <= OP_SET_CMP;
      r_idx      <= 2'd0;
      r_retry    <= '0;
      r_rsp_data <= 64'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_op       <= clint_op_e'(req_op_i);
            r_data     <= req_data_i;
            r_idx      <= 2'd0;
            r_retry    <= '0;
            r_rsp_data <= 64'd0;
            r_err      <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!w_done && w_timeout) r_err <= 1'b1;
        end
        ST_NEXT: begin
          if (r_op == OP_READ_CMP) begin
            if (r_idx == 2'd0) r_lo       <= w_rdat;
            else               r_rsp_data <= {w_rdat, r_lo};
          end else if (r_op == OP_READ_TIME) begin
            case (r_idx)
              2'd0: r_h1 <= w_rdat;
              2'd1: r_lo <= w_rdat;
              default: begin
                if (!w_hi_mismatch) begin
                  r_rsp_data <= {r_h1, r_lo};
                end else if (w_retry_left) begin
                  // The low word may have wrapped between the two high reads.
                  r_retry <= r_retry + RW'(1);
                end else begin
                  r_err      <= 1'b1;
                  r_rsp_data <= {w_rdat, r_lo};
                end
              end
            endcase
          end
          r_idx <= w_last ? 2'd0 : r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_access_sequencer.sv
module tb_clint_access_sequencer;
  import clint_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, m_rst;
  logic        rq_valid, rq_ready, rs_valid, rs_err, busy;
  logic [1:0]  rq_op;
  logic [63:0] rq_data, rs_data;
  logic        cyc, stb, we, ack;
  logic [31:0] adr, dato, rd_q;

  clint_access_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req_valid_i (rq_valid),
    .req_ready_o (rq_ready),
    .req_op_i    (rq_op),
    .req_data_i  (rq_data),
    .rsp_valid_o (rs_valid),
    .rsp_data_o  (rs_data),
    .rsp_err_o   (rs_err),
    .busy_o      (busy),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dato),
    .wbm_dat_i   (rd_q),
    .wbm_ack_i   (ack)
  );

  // ---------------- CLINT slave model ----------------
  logic [63:0] m_cmp, m_time;
  logic        noack, lo_bump, bump_en;
  logic [2:0]  acc_idx, bump_acc;
  logic [63:0] bump_val;
  int          dly [8];
  int          wcnt;
  logic [3:0]  wr_cnt;
  logic [31:0] wr_adr [16];
  logic [31:0] wr_dat [16];
  int          mtip_cnt;

  always_comb ack = cyc && stb && !noack && (wcnt >= dly[acc_idx]);

  always_ff @(posedge clk) begin
    if (m_rst) begin
      m_cmp <= 64'hFFFF_FFFF_FFFF_FFFF; m_time <= 64'd0;
      acc_idx <= 3'd0; wcnt <= 0; wr_cnt <= 4'd0; rd_q <= 32'd0; mtip_cnt <= 0;
    end else begin
      if (m_time >= m_cmp) mtip_cnt <= mtip_cnt + 1;
      if (cyc && stb && !ack) wcnt <= wcnt + 1; else wcnt <= 0;
      if (ack) begin
        acc_idx <= acc_idx + 3'd1;
        if (we) begin
          wr_adr[wr_cnt] <= adr; wr_dat[wr_cnt] <= dato; wr_cnt <= wr_cnt + 4'd1;
          case (adr)
            32'h2000_0C00: m_cmp[31:0]   <= dato;
            32'h2000_0C04: m_cmp[63:32]  <= dato;
            32'h2000_0C08: m_time[31:0]  <= dato;
            32'h2000_0C0C: m_time[63:32] <= dato;
            default: ;
          endcase
        end else begin
          case (adr)
            32'h2000_0C00: rd_q <= m_cmp[31:0];
            32'h2000_0C04: rd_q <= m_cmp[63:32];
            32'h2000_0C08: rd_q <= m_time[31:0];
            32'h2000_0C0C: rd_q <= m_time[63:32];
            default:       rd_q <= 32'hDEAD_BEEF;
          endcase
          if (bump_en && acc_idx == bump_acc) m_time <= bump_val;
          else if (lo_bump && adr == 32'h2000_0C08) m_time[63:32] <= m_time[63:32] + 32'd1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [63:0] d,
                        output logic [63:0] rd, output logic re, output int lat);
    int guard;
    guard = 0;
    while (!rq_ready && guard < 100) begin @(negedge clk); guard++; end
    rq_valid = 1'b1; rq_op = op; rq_data = d;
    @(negedge clk);
    rq_valid = 1'b0; rq_data = 64'd0;
    lat = 1;
    while (!rs_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rs_valid) begin
      n_chk++; n_fail++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles, required a response", lat);
    end
    rd = rs_data; re = rs_err;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t tv [8];

  logic [63:0] got_d, exp_d, ref_cmp, ref_time;
  logic        got_e;
  int          got_l, cnt, stbc, sumd, nacc, base, mt0, dv;
  logic [3:0]  w0;
  logic [2:0]  ix;
  logic [1:0]  op;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; m_rst = 1'b1; rq_valid = 1'b0; rq_op = 2'd0; rq_data = 64'd0;
    noack = 1'b0; lo_bump = 1'b0; bump_en = 1'b0; bump_acc = 3'd0; bump_val = 64'd0;
    for (int i = 0; i < 8; i++) dly[i] = 0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ready", rq_ready, 1); chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rs_valid, 0); chk("rst_rsp_err", rs_err, 0);
    chk("rst_rsp_data", rs_data, 0); chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0); chk("rst_we", we, 0);
    chk("rst_adr", adr, 0); chk("rst_dat", dato, 0);
    rst = 1'b0; m_rst = 1'b0;
    @(negedge clk);

    // back-to-back READ_CMP with valid held through busy
    rq_valid = 1'b1; rq_op = OP_READ_CMP;
    @(negedge clk);
    got_l = 1; cnt = 0;
    while (!rs_valid && got_l < 50) begin
      if (rq_ready) cnt++;
      @(negedge clk); got_l++;
    end
    chk("b2b_lat1", got_l, 7); chk("b2b_data1", rs_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b2b_err1", rs_err, 0); chk("b2b_ready_while_busy", cnt, 0);
    chk("b2b_busy_at_rsp", busy, 1);
    @(negedge clk);
    chk("b2b_ready_after_rsp", rq_ready, 1);
    @(negedge clk);
    rq_valid = 1'b0;
    got_l = 1;
    while (!rs_valid && got_l < 50) begin @(negedge clk); got_l++; end
    chk("b2b_lat2", got_l, 7); chk("b2b_data2", rs_data, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);

    // SET_CMP write ordering and no interrupt glitch (mtime is 0 here)
    w0 = wr_cnt; mt0 = mtip_cnt;
    do_req(OP_SET_CMP, 64'h0000_0001_0000_0100, got_d, got_e, got_l);
    chk("setcmp_lat", got_l, 7); chk("setcmp_err", got_e, 0); chk("setcmp_data", got_d, 0);
    chk("setcmp_nwr", 4'(wr_cnt - w0), 3);
    chk("setcmp_a0", wr_adr[w0], 32'h2000_0C04); chk("setcmp_d0", wr_dat[w0], 32'hFFFF_FFFF);
    chk("setcmp_a1", wr_adr[4'(w0 + 4'd1)], 32'h2000_0C00);
    chk("setcmp_d1", wr_dat[4'(w0 + 4'd1)], 32'h0000_0100);
    chk("setcmp_a2", wr_adr[4'(w0 + 4'd2)], 32'h2000_0C04);
    chk("setcmp_d2", wr_dat[4'(w0 + 4'd2)], 32'h0000_0001);
    chk("setcmp_mtip", mtip_cnt, mt0);
    chk("setcmp_model", m_cmp, 64'h0000_0001_0000_0100);

    // directed vector table
    tv[0] = '{OP_READ_CMP,  64'd0,                  64'h0000_0001_0000_0100, 1'b0, 7};
    tv[1] = '{OP_SET_TIME,  64'h0000_0002_FFFF_FFF0, 64'd0,                  1'b0, 7};
    tv[2] = '{OP_READ_TIME, 64'd0,                  64'h0000_0002_FFFF_FFF0, 1'b0, 10};
    tv[3] = '{OP_SET_CMP,   64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1'b0, 7};
    tv[4] = '{OP_READ_CMP,  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7};
    tv[5] = '{OP_SET_TIME,  64'h1234_5678_9ABC_DEF0, 64'd0,                  1'b0, 7};
    tv[6] = '{OP_READ_TIME, 64'hDEAD_DEAD_DEAD_DEAD, 64'h1234_5678_9ABC_DEF0, 1'b0, 10};
    tv[7] = '{OP_READ_CMP,  64'd0,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7};
    for (int i = 0; i < 8; i++) begin
      do_req(tv[i].op, tv[i].data, got_d, got_e, got_l);
      chk($sformatf("vec%0d_data", i), got_d, tv[i].exp_data);
      chk($sformatf("vec%0d_err", i), got_e, tv[i].exp_err);
      chk($sformatf("vec%0d_lat", i), got_l, tv[i].exp_lat);
    end

    // READ_TIME with one high-word change between h1 and h2
    do_req(OP_SET_TIME, 64'h0000_0002_FFFF_FFF0, got_d, got_e, got_l);
    bump_acc = acc_idx; bump_val = 64'h0000_0003_0000_0005; bump_en = 1'b1;
    do_req(OP_READ_TIME, 64'd0, got_d, got_e, got_l);
    bump_en = 1'b0;
    chk("retry1_data", got_d, 64'h0000_0003_0000_0005); chk("retry1_err", got_e, 0);

    // high word moves on every low read: retries exhaust
    lo_bump = 1'b1;
    do_req(OP_READ_TIME, 64'd0, got_d, got_e, got_l);
    lo_bump = 1'b0;
    chk("retryx_data", got_d, 64'h0000_0007_0000_0005); chk("retryx_err", got_e, 1);

    // slave never acks
    noack = 1'b1;
    rq_valid = 1'b1; rq_op = OP_READ_CMP;
    @(negedge clk);
    rq_valid = 1'b0; got_l = 1; stbc = 0;
    while (!rs_valid && got_l < 100) begin
      if (stb) stbc++;
      @(negedge clk); got_l++;
    end
    chk("tmo_stb_cycles", stbc, 16); chk("tmo_lat", got_l, 17);
    chk("tmo_valid", rs_valid, 1); chk("tmo_err", rs_err, 1);
    chk("tmo_cyc", cyc, 0); chk("tmo_stb", stb, 0);
    @(negedge clk);
    chk("tmo_ready_after", rq_ready, 1);
    noack = 1'b0;

    // randomized ops with random wait states against a transaction-level model
    for (int i = 0; i < 40; i++) begin
      op = (i == 0) ? OP_SET_TIME : (i == 1) ? OP_SET_CMP : 2'($urandom_range(0, 3));
      got_d = {$urandom, $urandom};
      exp_d = 64'd0;
      case (op)
        OP_SET_CMP:  ref_cmp = got_d;
        OP_SET_TIME: ref_time = got_d;
        OP_READ_CMP: exp_d = ref_cmp;
        default:     exp_d = ref_time;
      endcase
      nacc = (op == OP_READ_CMP) ? 2 : 3;
      base = (op == OP_READ_TIME) ? 10 : 7;
      sumd = 0;
      for (int k = 0; k < nacc; k++) begin
        dv = int'($urandom_range(0, 3));
        ix = acc_idx + 3'(k);
        dly[ix] = dv; sumd += dv;
      end
      do_req(op, got_d, got_d, got_e, got_l);
      chk($sformatf("rnd%0d_data", i), got_d, exp_d);
      chk($sformatf("rnd%0d_err", i), got_e, 0);
      chk($sformatf("rnd%0d_lat", i), got_l, base + sumd);
    end
    chk("rnd_model_cmp", m_cmp, ref_cmp);
    chk("rnd_model_time", m_time, ref_time);

    // reset during the second ISSUE of SET_TIME
    for (int i = 0; i < 8; i++) dly[i] = 0;
    rq_valid = 1'b1; rq_op = OP_SET_TIME; rq_data = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    rq_valid = 1'b0; got_l = 1;
    while (got_l < 3) begin @(negedge clk); got_l++; end
    chk("mid_issue2_stb", stb, 1); chk("mid_issue2_adr", adr, 32'h2000_0C0C);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_cyc", cyc, 0); chk("mid_stb", stb, 0);
    chk("mid_ready", rq_ready, 1); chk("mid_rsp_valid", rs_valid, 0);
    rst = 1'b0; cnt = 0;
    repeat (8) begin @(negedge clk); if (rs_valid) cnt++; end
    chk("mid_no_rsp", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
